qkv_operand_loader: RTL and testbench
=====================================

Name: qkv_operand_loader

Overview:
- Writer/initiator counterpart of the QKV attention multiplier.
- Accepts a word stream carrying the A header, A elements, B header and the Q/K/V weight elements.
- Writes those words into the input and weight SRAMs in the layout the multiplier reads.
- Then launches the multiplier over the dut_valid/dut_ready handshake and reports completion.

Parameters:
- ADDR_W, 16, SRAM address width (matches SRAM_ADDR_RANGE).
- DATA_W, 32, SRAM data and stream width (matches SRAM_DATA_RANGE).
- NUM_W, 3, number of weight matrices stored back to back in the weight SRAM (Q, K, V).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored unless in IDLE or ERROR.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  DATA_W  stream word.
- dut_valid  out  1  launch request to the multiplier.
- dut_ready  in  1  multiplier idle/ready.
- ldr__sram_input_write_enable  out  1  input SRAM write strobe.
- ldr__sram_input_write_address  out  ADDR_W  input SRAM write address.
- ldr__sram_input_write_data  out  DATA_W  input SRAM write data.
- ldr__sram_weight_write_enable  out  1  weight SRAM write strobe.
- ldr__sram_weight_write_address  out  ADDR_W  weight SRAM write address.
- ldr__sram_weight_write_data  out  DATA_W  weight SRAM write data.
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle pulse when the multiplier returns ready.
- err  out  1  sticky error flag; cleared by start or reset.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE; all outputs 0; counters 0. Reset mid-load or mid-launch aborts immediately. Partially written SRAM contents are don't-care.
- Header word format: {rows[31:16], cols[15:0]}.
- SRAM layout: input address 0 = A header, addresses 1..rA*cA = A row-major. Weight address 0 = B header, addresses 1..NUM_W*rB*cB = Q then K then V, each row-major.
- Writes are registered: an accepted beat at edge N appears on the write port (enable=1, address, data) during the cycle after N. Enable is 0 in every other cycle. At most one SRAM is written per cycle.
- s_ready = 1 only in HDR_A, DATA_A, HDR_B and DATA_B; no backpressure inside those states.
- IDLE: on start -> HDR_A; clear err.
- HDR_A: on beat, write input address 0. Latch rA and cA; remA = rA*cA (32-bit).
  - rA==0 or cA==0 -> ERROR.
  - remA+1 > 2^ADDR_W -> ERROR.
  - Otherwise -> DATA_A with address pointer = 1.
- DATA_A: each beat writes input[ptr]; ptr++; rem--. The beat that makes rem 0 -> HDR_B.
- HDR_B: on beat, write weight address 0. Latch rB and cB; remB = NUM_W*rB*cB.
  - Zero dimension -> ERROR.
  - rB != cA -> ERROR.
  - remB+1 > 2^ADDR_W -> ERROR.
  - Otherwise -> DATA_B with ptr = 1.
- DATA_B: same as DATA_A on the weight port. The final beat -> LAUNCH.
- Header write on error: in the ERROR cases of HDR_A/HDR_B the header word is still written, and err rises the cycle after the beat.
- LAUNCH: wait one cycle so the final write lands. Then, when dut_ready=1, drive dut_valid=1 for exactly one cycle -> WAIT_ACCEPT. If dut_ready=0, hold dut_valid=0 and wait.
- WAIT_ACCEPT: when dut_ready=0 -> WAIT_DONE.
- WAIT_DONE: when dut_ready=1 -> pulse done for one cycle -> IDLE.
- ERROR: s_ready=0, dut_valid=0, err=1. Leave only via start (-> HDR_A, err cleared) or reset.
- A start pulse while busy is ignored; no effect on state or err.
- s_valid while s_ready=0 is ignored and never written.

Decomposition:
- Shared package qkv_pkg holds:
  - state enum: IDLE, HDR_A, DATA_A, HDR_B, DATA_B, LAUNCH, WAIT_ACCEPT, WAIT_DONE, ERROR;
  - header field slices (ROWS_MSB=31, ROWS_LSB=16, COLS_MSB=15, COLS_LSB=0);
  - HDR_ADDR=0 and DATA_BASE=1.
- One natural sub-module: qkv_sram_wr_port. It is the registered write-port stage (enable/address/data flops with a synchronous clear) and is instantiated twice, once for input and once for weight.

Test Plan:
- 2x2 A (header 0x00020002; A = 1,2,3,4), B header 0x00020002 with 12 weights 1..12: expect input writes at addresses 0..4, weight writes at addresses 0..12, then one dut_valid pulse, then done one cycle after dut_ready re-rises.
- Same load with s_valid toggled every other cycle: write addresses and data are identical, no gaps skip an address, and no write occurs on an idle cycle.
- A header 0x00030002 with B header 0x00030002 (rB != cA): B header is written to weight address 0, err=1, s_ready=0, no dut_valid; a later start clears err.
- A header 0x00000004: err=1 after the header beat, no further writes.
- dut_ready held 0 for 20 cycles in LAUNCH: dut_valid stays 0. Raise dut_ready: exactly one dut_valid cycle.
- reset_n=0 during DATA_B: all outputs are 0 on the next cycle, state IDLE, and stream words are ignored until start.

Source files
------------

// File: rtl/qkv_pkg.sv
// Shared types and constants for the QKV operand loader.
// Holds the loader state encoding, the header word field positions,
// the fixed SRAM addresses of header and first data word, and a header decoder.
package qkv_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        HDR_A       = 4'd1,
        DATA_A      = 4'd2,
        HDR_B       = 4'd3,
        DATA_B      = 4'd4,
        LAUNCH      = 4'd5,
        WAIT_ACCEPT = 4'd6,
        WAIT_DONE   = 4'd7,
        ERROR       = 4'd8
    } qkv_state_e;

    localparam int unsigned ROWS_MSB  = 31;
    localparam int unsigned ROWS_LSB  = 16;
    localparam int unsigned COLS_MSB  = 15;
    localparam int unsigned COLS_LSB  = 0;
    localparam int unsigned DIM_W     = ROWS_MSB - ROWS_LSB + 1;

    localparam int unsigned HDR_ADDR  = 0;
    localparam int unsigned DATA_BASE = 1;

    typedef struct packed {
        logic [DIM_W-1:0] rows;
        logic [DIM_W-1:0] cols;
    } qkv_hdr_t;

    // Split a header word into its row and column counts.
    function automatic qkv_hdr_t hdr_decode(input logic [ROWS_MSB:COLS_LSB] word);
        qkv_hdr_t h;
        h.rows = word[ROWS_MSB:ROWS_LSB];
        h.cols = word[COLS_MSB:COLS_LSB];
        return h;
    endfunction

endpackage

// File: rtl/qkv_operand_loader_if.sv
// Word stream carrying headers and matrix elements into the loader.
// master: produces s_valid/s_data, observes s_ready.
// slave : consumes s_valid/s_data, drives s_ready.
interface qkv_operand_loader_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/qkv_sram_wr_port.sv
// Registered SRAM write-port stage.
// Ports: clk, reset_n (synchronous clear), wr_en_c/wr_addr_c/wr_data_c (request
// in the current cycle), we/addr/data (write presented to the SRAM next cycle).
// Address and data read as zero whenever no write is being presented.
module qkv_sram_wr_port #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en_c,
    input  logic [ADDR_W-1:0] wr_addr_c,
    input  logic [DATA_W-1:0] wr_data_c,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // One-cycle write register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we   <= 1'b0;
            addr <= '0;
            data <= '0;
        end else begin
            we   <= wr_en_c;
            addr <= wr_en_c ? wr_addr_c : '0;
            data <= wr_en_c ? wr_data_c : '0;
        end
    end

endmodule

// File: rtl/qkv_operand_loader.sv
// QKV operand loader: writes the A matrix into the input SRAM and the B header
// plus Q/K/V weights into the weight SRAM, then launches the multiplier.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start              load request pulse (honoured in IDLE or ERROR only)
//   s_if               word stream (slave side)
//   dut_valid/ready    multiplier launch handshake
//   ldr__sram_input_*  input SRAM write port
//   ldr__sram_weight_* weight SRAM write port
//   busy, done, err    status: active, completion pulse, sticky error
module qkv_operand_loader
    import qkv_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    qkv_operand_loader_if.slave   s_if,
    output logic                  dut_valid,
    input  logic                  dut_ready,
    output logic                  ldr__sram_input_write_enable,
    output logic [ADDR_W-1:0]     ldr__sram_input_write_address,
    output logic [DATA_W-1:0]     ldr__sram_input_write_data,
    output logic                  ldr__sram_weight_write_enable,
    output logic [ADDR_W-1:0]     ldr__sram_weight_write_address,
    output logic [DATA_W-1:0]     ldr__sram_weight_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W  = 32;
    // Wide enough for NUM_W * rows * cols without overflow.
    localparam int unsigned PROD_W = 2 * DIM_W + 8;
    localparam logic [PROD_W-1:0] SPAN_MAX = (PROD_W'(1) << ADDR_W) - PROD_W'(1);

    qkv_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  rem_q;
    logic [DIM_W-1:0]  cols_a_q;
    logic              s_ready_q;

    logic              beat_c;
    qkv_hdr_t          hdr_c;
    logic [PROD_W-1:0] prod_a_c;
    logic [PROD_W-1:0] prod_b_c;
    logic              a_bad_c;
    logic              b_bad_c;
    logic              last_c;

    logic              in_wr_en_c;
    logic [ADDR_W-1:0] in_wr_addr_c;
    logic              wt_wr_en_c;
    logic [ADDR_W-1:0] wt_wr_addr_c;
    logic              s_ready_d;
    logic              busy_d;
    logic              err_d;
    logic              dut_valid_d;
    logic              done_d;

    assign s_if.s_ready = s_ready_q;
    assign beat_c       = s_if.s_valid && s_ready_q;

    // Header decode and dimension checks; element counts must fit behind the header.
    assign hdr_c    = hdr_decode(s_if.s_data[ROWS_MSB:COLS_LSB]);
    assign prod_a_c = PROD_W'(hdr_c.rows) * PROD_W'(hdr_c.cols);
    assign prod_b_c = PROD_W'(NUM_W) * prod_a_c;
    assign a_bad_c  = (hdr_c.rows == '0) || (hdr_c.cols == '0) || (prod_a_c > SPAN_MAX);
    assign b_bad_c  = (hdr_c.rows == '0) || (hdr_c.cols == '0) ||
                      (hdr_c.rows != cols_a_q) || (prod_b_c > SPAN_MAX);
    assign last_c   = (rem_q == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ERROR: begin
                if (start) state_d = HDR_A;
            end
            HDR_A: begin
                if (beat_c) state_d = a_bad_c ? ERROR : DATA_A;
            end
            DATA_A: begin
                if (beat_c && last_c) state_d = HDR_B;
            end
            HDR_B: begin
                if (beat_c) state_d = b_bad_c ? ERROR : DATA_B;
            end
            DATA_B: begin
                if (beat_c && last_c) state_d = LAUNCH;
            end
            // First LAUNCH cycle is the one in which the final weight write lands.
            LAUNCH: begin
                if (dut_ready) state_d = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (!dut_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (dut_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: write requests this cycle and next values of status flops.
    always_comb begin
        in_wr_en_c   = 1'b0;
        in_wr_addr_c = '0;
        wt_wr_en_c   = 1'b0;
        wt_wr_addr_c = '0;
        dut_valid_d  = 1'b0;
        done_d       = 1'b0;
        s_ready_d    = (state_d == HDR_A) || (state_d == DATA_A) ||
                       (state_d == HDR_B) || (state_d == DATA_B);
        busy_d       = (state_d != IDLE) && (state_d != ERROR);
        err_d        = (state_d == ERROR);
        case (state_q)
            HDR_A: begin
                in_wr_en_c   = beat_c;
                in_wr_addr_c = ADDR_W'(HDR_ADDR);
            end
            DATA_A: begin
                in_wr_en_c   = beat_c;
                in_wr_addr_c = ptr_q;
            end
            HDR_B: begin
                wt_wr_en_c   = beat_c;
                wt_wr_addr_c = ADDR_W'(HDR_ADDR);
            end
            DATA_B: begin
                wt_wr_en_c   = beat_c;
                wt_wr_addr_c = ptr_q;
            end
            LAUNCH:    dut_valid_d = dut_ready;
            WAIT_DONE: done_d      = dut_ready;
            default: ;
        endcase
    end

    // Address pointer, remaining-element counter, A column count and status flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            rem_q     <= '0;
            cols_a_q  <= '0;
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            dut_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            s_ready_q <= s_ready_d;
            busy      <= busy_d;
            err       <= err_d;
            dut_valid <= dut_valid_d;
            done      <= done_d;
            if (beat_c) begin
                case (state_q)
                    HDR_A: begin
                        cols_a_q <= hdr_c.cols;
                        rem_q    <= CNT_W'(prod_a_c);
                        ptr_q    <= ADDR_W'(DATA_BASE);
                    end
                    HDR_B: begin
                        rem_q <= CNT_W'(prod_b_c);
                        ptr_q <= ADDR_W'(DATA_BASE);
                    end
                    DATA_A, DATA_B: begin
                        rem_q <= rem_q - CNT_W'(1);
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    qkv_sram_wr_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_in_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_c   (in_wr_en_c),
        .wr_addr_c (in_wr_addr_c),
        .wr_data_c (s_if.s_data),
        .we        (ldr__sram_input_write_enable),
        .addr      (ldr__sram_input_write_address),
        .data      (ldr__sram_input_write_data)
    );

    qkv_sram_wr_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wt_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_c   (wt_wr_en_c),
        .wr_addr_c (wt_wr_addr_c),
        .wr_data_c (s_if.s_data),
        .we        (ldr__sram_weight_write_enable),
        .addr      (ldr__sram_weight_write_address),
        .data      (ldr__sram_weight_write_data)
    );

endmodule

// File: tb/tb_qkv_operand_loader.sv
// Bench for qkv_operand_loader: scoreboarded SRAM writes plus a simple
// multiplier model on the dut_valid/dut_ready handshake.
module tb_qkv_operand_loader;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_W  = 3;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              dut_valid;
    logic              dut_ready;
    logic              in_we, wt_we;
    logic [ADDR_W-1:0] in_addr, wt_addr;
    logic [DATA_W-1:0] in_data, wt_data;
    logic              busy, done, err;

    qkv_operand_loader_if #(.DATA_W(DATA_W)) s_if ();

    qkv_operand_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_W  (NUM_W)
    ) dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .start                          (start),
        .s_if                           (s_if),
        .dut_valid                      (dut_valid),
        .dut_ready                      (dut_ready),
        .ldr__sram_input_write_enable   (in_we),
        .ldr__sram_input_write_address  (in_addr),
        .ldr__sram_input_write_data     (in_data),
        .ldr__sram_weight_write_enable  (wt_we),
        .ldr__sram_weight_write_address (wt_addr),
        .ldr__sram_weight_write_data    (wt_data),
        .busy                           (busy),
        .done                           (done),
        .err                            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    logic [47:0] in_q[$];
    logic [47:0] wt_q[$];
    int dv_cnt = 0, done_cnt = 0, dv_cyc = 0, rise_cyc = 0, last_wt_cyc = 0;
    bit dv_prev = 0, done_prev = 0;
    bit hold_ready = 0;
    int mult_cnt = 0;

    // Multiplier model: accepts a launch, stays busy 5 cycles, then returns ready.
    initial begin
        dut_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (hold_ready) dut_ready = 1'b0;
            else if (mult_cnt > 0) begin
                mult_cnt--;
                if (mult_cnt == 0) begin
                    dut_ready = 1'b1;
                    rise_cyc  = cyc;
                end
            end else if (dut_valid && dut_ready) begin
                dut_ready = 1'b0;
                mult_cnt  = 5;
            end else dut_ready = 1'b1;
        end
    end

    // Write and handshake monitor.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (in_we) begin
                if (in_q.size() == 0) check("in_extra_write", 64'(in_we), 64'(0));
                else begin
                    e = in_q.pop_front();
                    check("in_write", 64'({in_addr, in_data}), 64'(e));
                end
            end
            if (wt_we) begin
                last_wt_cyc = cyc;
                if (wt_q.size() == 0) check("wt_extra_write", 64'(wt_we), 64'(0));
                else begin
                    e = wt_q.pop_front();
                    check("wt_write", 64'({wt_addr, wt_data}), 64'(e));
                end
            end
            if (in_we || wt_we) check("one_port", 64'(in_we & wt_we), 64'(0));
            if (dut_valid) begin
                dv_cnt++;
                dv_cyc = cyc;
                check("dv_single", 64'(dv_prev), 64'(0));
            end
            if (done) begin
                done_cnt++;
                check("done_single", 64'(done_prev), 64'(0));
                check("done_latency", 64'(cyc - rise_cyc), 64'(1));
            end
            dv_prev   = dut_valid;
            done_prev = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Offer one beat once s_ready is seen; records its expected SRAM write.
    task automatic send(input logic [31:0] w, input bit is_wt, input int addr, input int gap);
        bit ok = 0;
        repeat (gap) begin
            @(negedge clk);
            s_if.s_valid = 1'b0;
            s_if.s_data  = JUNK;
        end
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (s_if.s_ready) begin
                s_if.s_valid = 1'b1;
                s_if.s_data  = w;
                if (is_wt) wt_q.push_back({16'(addr), w});
                else       in_q.push_back({16'(addr), w});
                ok = 1;
                break;
            end
            s_if.s_valid = 1'b0;
        end
        if (!ok) check("s_ready_timeout", 64'(s_if.s_ready), 64'(1));
    endtask

    task automatic end_stream();
        @(negedge clk);
        s_if.s_valid = 1'b0;
        s_if.s_data  = JUNK;
    endtask

    task automatic send_a(input logic [31:0] ha, input int gap);
        int n = int'(ha[31:16]) * int'(ha[15:0]);
        send(ha, 1'b0, 0, gap);
        for (int i = 0; i < n; i++) send(32'(i + 1), 1'b0, i + 1, gap);
    endtask

    task automatic send_b(input logic [31:0] hb, input int n, input int gap);
        send(hb, 1'b1, 0, gap);
        for (int i = 0; i < n; i++) send(32'(i + 1), 1'b1, i + 1, gap);
    endtask

    task automatic do_load(input logic [31:0] ha, input logic [31:0] hb, input int gap);
        send_a(ha, gap);
        send_b(hb, int'(NUM_W) * int'(hb[31:16]) * int'(hb[15:0]), gap);
        end_stream();
    endtask

    task automatic wait_done(input int base);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (done_cnt > base) break;
        end
        check("done_seen", 64'(done_cnt), 64'(base + 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_we"},   64'(in_we),       64'(0));
        check({tag, "_wt_we"},   64'(wt_we),       64'(0));
        check({tag, "_s_ready"}, 64'(s_if.s_ready), 64'(0));
        check({tag, "_busy"},    64'(busy),        64'(0));
        check({tag, "_done"},    64'(done),        64'(0));
        check({tag, "_err"},     64'(err),         64'(0));
        check({tag, "_dv"},      64'(dut_valid),   64'(0));
    endtask

    task automatic full_load_check(input string tag, input int gap);
        int dv0 = dv_cnt;
        int dn0 = done_cnt;
        pulse_start();
        do_load(32'h0002_0002, 32'h0002_0002, gap);
        wait_done(dn0);
        check({tag, "_dv_count"},   64'(dv_cnt), 64'(dv0 + 1));
        check({tag, "_dv_after_wr"}, 64'(dv_cyc > last_wt_cyc), 64'(1));
        check({tag, "_in_q_empty"}, 64'(in_q.size()), 64'(0));
        check({tag, "_wt_q_empty"}, 64'(wt_q.size()), 64'(0));
        check({tag, "_busy_end"},   64'(busy), 64'(0));
        check({tag, "_err_end"},    64'(err), 64'(0));
    endtask

    initial begin
        int dv0;
        reset_n      = 1'b0;
        start        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = JUNK;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Back-to-back 2x2 load.
        full_load_check("basic", 0);

        // Same load with s_valid every other cycle.
        full_load_check("gapped", 1);

        // rB != cA: B header written, then ERROR.
        dv0 = dv_cnt;
        pulse_start();
        send_a(32'h0003_0002, 0);
        send(32'h0003_0002, 1'b1, 0, 0);
        end_stream();
        check("dim_err", 64'(err), 64'(1));
        check("dim_err_s_ready", 64'(s_if.s_ready), 64'(0));
        check("dim_err_busy", 64'(busy), 64'(0));
        s_if.s_valid = 1'b1;
        repeat (8) @(negedge clk);
        s_if.s_valid = 1'b0;
        #1;
        check("dim_err_no_dv", 64'(dv_cnt), 64'(dv0));
        check("dim_err_sticky", 64'(err), 64'(1));
        check("dim_err_wt_q", 64'(wt_q.size()), 64'(0));
        pulse_start();
        check("start_clears_err", 64'(err), 64'(0));
        check("restart_s_ready", 64'(s_if.s_ready), 64'(1));

        // Zero-row A header: header written, then ERROR, no further writes.
        send(32'h0000_0004, 1'b0, 0, 0);
        end_stream();
        check("zero_dim_err", 64'(err), 64'(1));
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'h0002_0002;
        repeat (6) @(negedge clk);
        s_if.s_valid = 1'b0;
        #1;
        check("zero_dim_in_q", 64'(in_q.size()), 64'(0));

        // dut_ready held low in LAUNCH; start while busy is ignored.
        dv0 = dv_cnt;
        hold_ready = 1'b1;
        pulse_start();
        do_load(32'h0002_0002, 32'h0002_0002, 0);
        repeat (20) @(negedge clk);
        #1;
        check("hold_no_dv", 64'(dv_cnt), 64'(dv0));
        check("hold_busy", 64'(busy), 64'(1));
        pulse_start();
        check("busy_start_busy", 64'(busy), 64'(1));
        check("busy_start_s_ready", 64'(s_if.s_ready), 64'(0));
        hold_ready = 1'b0;
        wait_done(done_cnt);
        check("hold_dv_count", 64'(dv_cnt), 64'(dv0 + 1));

        // Reset during DATA_B.
        pulse_start();
        send_a(32'h0002_0002, 0);
        send_b(32'h0002_0002, 5, 0);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        reset_n      = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset_n      = 1'b1;
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'h0000_0007;
        repeat (6) @(negedge clk);
        check("post_reset_s_ready", 64'(s_if.s_ready), 64'(0));
        s_if.s_valid = 1'b0;
        #1;
        check("post_reset_in_q", 64'(in_q.size()), 64'(0));
        check("post_reset_wt_q", 64'(wt_q.size()), 64'(0));
        full_load_check("after_reset", 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
